// File: rtl/btb_2way_tagged_pkg.sv
// Shared defaults and way-select encoding for the 2-way tagged BTB.
package btb_2way_tagged_pkg;

  localparam int DEF_PC_W  = 16;
  localparam int DEF_IDX_W = 4;

  // Way-select encoding; also the meaning of each per-set LRU bit (victim way).
  typedef enum logic {
    WAY0 = 1'b0,
    WAY1 = 1'b1
  } way_e;

endpackage

// File: rtl/btb_2way_tagged_way.sv
// One BTB way: SETS entries of {valid, tag, target}.
// Two combinational read ports (fetch lookup and resolved-branch update), each with its own tag compare.
// One synchronous write/clear port at the update index.
// Priority is rst > flush > write > clear.
module btb_2way_tagged_way #(
  parameter int PC_W  = 16,
  parameter int IDX_W = 4,
  parameter int TAG_W = PC_W - IDX_W - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [TAG_W-1:0] i_rd_tag,
  output logic             o_rd_hit,
  output logic [PC_W-1:0]  o_rd_target,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic [TAG_W-1:0] i_upd_tag,
  output logic             o_upd_hit,
  output logic             o_upd_valid,
  input  logic             i_wr_en,
  input  logic [PC_W-1:0]  i_wr_target,
  input  logic             i_clr_en
);

  localparam int SETS = 2 ** IDX_W;

  logic             r_valid  [SETS];
  logic [TAG_W-1:0] r_tag    [SETS];
  logic [PC_W-1:0]  r_target [SETS];

  // Entry storage: reset clears everything, flush only drops valid bits (tags/targets may go stale).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SETS; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
      end
    end else if (i_flush) begin
      for (int i = 0; i < SETS; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (i_wr_en) begin
      r_valid[i_upd_idx]  <= 1'b1;
      r_tag[i_upd_idx]    <= i_upd_tag;
      r_target[i_upd_idx] <= i_wr_target;
    end else if (i_clr_en) begin
      r_valid[i_upd_idx] <= 1'b0;
    end
  end

  assign o_rd_hit    = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_rd_target = r_target[i_rd_idx];
  assign o_upd_valid = r_valid[i_upd_idx];
  assign o_upd_hit   = r_valid[i_upd_idx] && (r_tag[i_upd_idx] == i_upd_tag);

endmodule

// File: rtl/btb_2way_tagged.sv
// 2-way set-associative tagged branch target buffer.
// Lookup is combinational with no bypass: an update is visible one cycle after its edge.
// Taken updates allocate or refresh an entry; not-taken updates invalidate a matching entry.
// Each set has an LRU bit naming its next victim way.
module btb_2way_tagged
  import btb_2way_tagged_pkg::*;
#(
  parameter int PC_W  = DEF_PC_W,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [PC_W-1:0] lookup_pc,
  output logic            hit,
  output logic [PC_W-1:0] predicted_target,
  input  logic            upd_en,
  input  logic [PC_W-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [PC_W-1:0] upd_target
);

  localparam int TAG_W = PC_W - IDX_W - 1;
  localparam int SETS  = 2 ** IDX_W;

  logic [IDX_W-1:0] w_l_idx, w_u_idx;
  logic [TAG_W-1:0] w_l_tag, w_u_tag;
  logic             w_l_hit0, w_l_hit1;
  logic [PC_W-1:0]  w_l_tgt0, w_l_tgt1;
  logic             w_u_hit0, w_u_hit1, w_u_val0, w_u_val1;
  logic             w_u_hit;
  way_e             w_hit_way, w_victim, w_wr_way;
  logic             w_wr0, w_wr1, w_clr0, w_clr1;
  logic             w_unused_pc0;
  logic [SETS-1:0]  r_lru;

  // Bit 0 is never part of the address: instructions are halfword aligned.
  assign w_unused_pc0 = lookup_pc[0] ^ upd_pc[0];

  assign w_l_idx = lookup_pc[IDX_W:1];
  assign w_l_tag = lookup_pc[PC_W-1:IDX_W+1];
  assign w_u_idx = upd_pc[IDX_W:1];
  assign w_u_tag = upd_pc[PC_W-1:IDX_W+1];

  // Way 0 takes precedence wherever both ways could match.
  assign w_u_hit   = w_u_hit0 | w_u_hit1;
  assign w_hit_way = w_u_hit0 ? WAY0 : WAY1;
  assign w_victim  = !w_u_val0 ? WAY0 : (!w_u_val1 ? WAY1 : way_e'(r_lru[w_u_idx]));
  assign w_wr_way  = w_u_hit ? w_hit_way : w_victim;

  assign w_wr0  = upd_en && upd_taken && (w_wr_way == WAY0);
  assign w_wr1  = upd_en && upd_taken && (w_wr_way == WAY1);
  assign w_clr0 = upd_en && !upd_taken && w_u_hit && (w_hit_way == WAY0);
  assign w_clr1 = upd_en && !upd_taken && w_u_hit && (w_hit_way == WAY1);

  btb_2way_tagged_way #(.PC_W(PC_W), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_way0 (
    .clk(clk), .rst(rst), .i_flush(flush),
    .i_rd_idx(w_l_idx), .i_rd_tag(w_l_tag), .o_rd_hit(w_l_hit0), .o_rd_target(w_l_tgt0),
    .i_upd_idx(w_u_idx), .i_upd_tag(w_u_tag), .o_upd_hit(w_u_hit0), .o_upd_valid(w_u_val0),
    .i_wr_en(w_wr0), .i_wr_target(upd_target), .i_clr_en(w_clr0)
  );

  btb_2way_tagged_way #(.PC_W(PC_W), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_way1 (
    .clk(clk), .rst(rst), .i_flush(flush),
    .i_rd_idx(w_l_idx), .i_rd_tag(w_l_tag), .o_rd_hit(w_l_hit1), .o_rd_target(w_l_tgt1),
    .i_upd_idx(w_u_idx), .i_upd_tag(w_u_tag), .o_upd_hit(w_u_hit1), .o_upd_valid(w_u_val1),
    .i_wr_en(w_wr1), .i_wr_target(upd_target), .i_clr_en(w_clr1)
  );

  // LRU: after a write the other way becomes victim; after an invalidate the freed way becomes victim.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lru <= '0;
    end else if (flush) begin
      r_lru <= '0;
    end else if (upd_en) begin
      if (upd_taken) begin
        r_lru[w_u_idx] <= (w_wr_way == WAY0) ? WAY1 : WAY0;
      end else if (w_u_hit) begin
        r_lru[w_u_idx] <= w_hit_way;
      end
    end
  end

  assign hit              = w_l_hit0 | w_l_hit1;
  assign predicted_target = w_l_hit0 ? w_l_tgt0 : (w_l_hit1 ? w_l_tgt1 : '0);

endmodule

// File: tb/tb_btb_2way_tagged.sv
// Bench for btb_2way_tagged: directed vector table, flush/reset sequences, random run against a reference model.
module tb_btb_2way_tagged;

  localparam int PC_W  = 16;
  localparam int IDX_W = 4;
  localparam int TAG_W = PC_W - IDX_W - 1;
  localparam int SETS  = 2 ** IDX_W;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [PC_W-1:0] lookup_pc;
  logic            hit;
  logic [PC_W-1:0] predicted_target;
  logic            upd_en;
  logic [PC_W-1:0] upd_pc;
  logic            upd_taken;
  logic [PC_W-1:0] upd_target;

  typedef struct {
    logic            rst;
    logic            flush;
    logic            upd_en;
    logic [PC_W-1:0] upd_pc;
    logic            taken;
    logic [PC_W-1:0] upd_tgt;
    logic [PC_W-1:0] lk_pc;
    logic            exp_hit;
    logic [PC_W-1:0] exp_tgt;
  } vec_t;

  vec_t            tab[$];
  logic [PC_W:0]   exp_q[$];
  int              checks;
  int              errors;

  // Reference model state
  logic            m_valid [2][SETS];
  logic [TAG_W-1:0] m_tag  [2][SETS];
  logic [PC_W-1:0] m_tgt   [2][SETS];
  logic            m_lru   [SETS];

  btb_2way_tagged dut (
    .clk(clk), .rst(rst), .flush(flush),
    .lookup_pc(lookup_pc), .hit(hit), .predicted_target(predicted_target),
    .upd_en(upd_en), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(input logic r, input logic f, input logic ue, input logic [PC_W-1:0] up,
                              input logic tk, input logic [PC_W-1:0] ut, input logic [PC_W-1:0] lk,
                              input logic eh, input logic [PC_W-1:0] et);
    vec_t v;
    v.rst = r; v.flush = f; v.upd_en = ue; v.upd_pc = up; v.taken = tk;
    v.upd_tgt = ut; v.lk_pc = lk; v.exp_hit = eh; v.exp_tgt = et;
    return v;
  endfunction

  function automatic logic [PC_W:0] model_lookup(input logic [PC_W-1:0] pc);
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    idx = pc[IDX_W:1];
    tag = pc[PC_W-1:IDX_W+1];
    for (int w = 0; w < 2; w++) begin
      if (m_valid[w][idx] && m_tag[w][idx] == tag) return {1'b1, m_tgt[w][idx]};
    end
    return '0;
  endfunction

  function automatic void model_update(input vec_t v);
    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    int hw;
    int vw;
    idx = v.upd_pc[IDX_W:1];
    tag = v.upd_pc[PC_W-1:IDX_W+1];
    if (v.rst) begin
      for (int s = 0; s < SETS; s++) begin
        m_lru[s] = 1'b0;
        for (int w = 0; w < 2; w++) begin
          m_valid[w][s] = 1'b0; m_tag[w][s] = '0; m_tgt[w][s] = '0;
        end
      end
    end else if (v.flush) begin
      for (int s = 0; s < SETS; s++) begin
        m_lru[s] = 1'b0;
        m_valid[0][s] = 1'b0;
        m_valid[1][s] = 1'b0;
      end
    end else if (v.upd_en) begin
      hw = -1;
      if (m_valid[1][idx] && m_tag[1][idx] == tag) hw = 1;
      if (m_valid[0][idx] && m_tag[0][idx] == tag) hw = 0;
      if (v.taken) begin
        if (hw >= 0) vw = hw;
        else if (!m_valid[0][idx]) vw = 0;
        else if (!m_valid[1][idx]) vw = 1;
        else vw = int'(m_lru[idx]);
        m_valid[vw][idx] = 1'b1;
        m_tag[vw][idx]   = tag;
        m_tgt[vw][idx]   = v.upd_tgt;
        m_lru[idx]       = (vw == 0);
      end else if (hw >= 0) begin
        m_valid[hw][idx] = 1'b0;
        m_lru[idx]       = (hw == 1);
      end
    end
  endfunction

  // Driver: inputs change on the falling edge, well away from the active edge.
  task automatic drive(input vec_t v);
    rst        = v.rst;
    flush      = v.flush;
    upd_en     = v.upd_en;
    upd_pc     = v.upd_pc;
    upd_taken  = v.taken;
    upd_target = v.upd_tgt;
    lookup_pc  = v.lk_pc;
  endtask

  // Scoreboard pop and compare
  task automatic check(input string name);
    logic [PC_W:0] exp;
    exp = exp_q.pop_front();
    checks++;
    if ({hit, predicted_target} !== exp) begin
      errors++;
      $display("FAIL %s: lookup_pc=%h got hit=%0b tgt=%h, expected hit=%0b tgt=%h",
               name, lookup_pc, hit, predicted_target, exp[PC_W], exp[PC_W-1:0]);
    end
    checks++;
    if (dut.w_l_hit0 && dut.w_l_hit1) begin
      errors++;
      $display("FAIL dual_hit %s: lookup_pc=%h got both ways hit, expected at most one", name, lookup_pc);
    end
  endtask

  // One cycle: drive, push expectation, sample before the rising edge, then advance the model.
  task automatic step(input vec_t v, input bit from_model, input string name);
    @(negedge clk);
    drive(v);
    if (from_model) exp_q.push_back(model_lookup(v.lk_pc));
    else            exp_q.push_back({v.exp_hit, v.exp_tgt});
    #2;
    check(name);
    @(posedge clk);
    model_update(v);
  endtask

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;
    drive(mk(0, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 16'h0));

    // Reset for one cycle, then sweep every halfword-aligned PC
    @(negedge clk);
    v = mk(1, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 16'h0);
    drive(v);
    @(posedge clk);
    model_update(v);
    for (int pc = 0; pc < 65536; pc += 2) begin
      step(mk(0, 0, 0, 16'h0, 0, 16'h0, 16'(pc), 0, 16'h0), 0, "reset_sweep");
    end

    // Directed table: allocate, no bypass, associativity, LRU, not-taken, pc[0], top set
    //            rst flush en  upd_pc    tk  upd_tgt   lookup    hit tgt
    tab.push_back(mk(0, 0, 1, 16'h0012, 1, 16'h0400, 16'h0012, 0, 16'h0000));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0012, 1, 16'h0400));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0212, 0, 16'h0000));
    tab.push_back(mk(0, 0, 1, 16'h0212, 1, 16'h0500, 16'h0012, 1, 16'h0400));
    tab.push_back(mk(0, 0, 1, 16'h0412, 1, 16'h0600, 16'h0212, 1, 16'h0500));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0012, 0, 16'h0000));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0212, 1, 16'h0500));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0412, 1, 16'h0600));
    tab.push_back(mk(0, 0, 1, 16'h0212, 1, 16'h0500, 16'h0412, 1, 16'h0600));
    tab.push_back(mk(0, 0, 1, 16'h0612, 1, 16'h0700, 16'h0612, 0, 16'h0000));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0412, 0, 16'h0000));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0612, 1, 16'h0700));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0212, 1, 16'h0500));
    tab.push_back(mk(1, 0, 1, 16'h0812, 1, 16'h0900, 16'h0212, 1, 16'h0500));
    tab.push_back(mk(0, 0, 1, 16'h0012, 1, 16'h0400, 16'h0212, 0, 16'h0000));
    tab.push_back(mk(0, 0, 1, 16'h0212, 1, 16'h0500, 16'h0012, 1, 16'h0400));
    tab.push_back(mk(0, 0, 1, 16'h0012, 0, 16'h0000, 16'h0012, 1, 16'h0400));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0012, 0, 16'h0000));
    tab.push_back(mk(0, 0, 1, 16'h0812, 1, 16'h0800, 16'h0212, 1, 16'h0500));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0812, 1, 16'h0800));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0212, 1, 16'h0500));
    tab.push_back(mk(0, 0, 1, 16'h0A12, 0, 16'h0000, 16'h0A12, 0, 16'h0000));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0812, 1, 16'h0800));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0212, 1, 16'h0500));
    tab.push_back(mk(0, 0, 1, 16'h0212, 0, 16'h0000, 16'h0212, 1, 16'h0500));
    tab.push_back(mk(0, 0, 1, 16'h0C12, 1, 16'h0C00, 16'h0212, 0, 16'h0000));
    tab.push_back(mk(0, 0, 1, 16'h0E12, 1, 16'h0E00, 16'h0C12, 1, 16'h0C00));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0812, 0, 16'h0000));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0C12, 1, 16'h0C00));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0E12, 1, 16'h0E00));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h0E13, 1, 16'h0E00));
    tab.push_back(mk(0, 0, 1, 16'hFFFE, 1, 16'h1234, 16'hFFFE, 0, 16'h0000));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'hFFFE, 1, 16'h1234));
    tab.push_back(mk(0, 0, 0, 16'h0000, 0, 16'h0000, 16'h001E, 0, 16'h0000));
    for (int i = 0; i < tab.size(); i++) begin
      step(tab[i], 0, $sformatf("vec%0d", i));
    end

    // Fill every set, confirm, then flush with a coincident taken update
    for (int s = 0; s < SETS; s++) begin
      step(mk(0, 0, 1, 16'(32'h20 | (s << 1)), 1, 16'(32'h1000 + s), 16'h0000, 0, 16'h0), 1, "fill");
    end
    for (int s = 0; s < SETS; s++) begin
      step(mk(0, 0, 0, 16'h0, 0, 16'h0, 16'(32'h20 | (s << 1)), 1, 16'(32'h1000 + s)), 0, "fill_hit");
    end
    step(mk(0, 1, 1, 16'h0004, 1, 16'h4444, 16'h0024, 1, 16'h1002), 0, "flush_cycle");
    for (int s = 0; s < SETS; s++) begin
      step(mk(0, 0, 0, 16'h0, 0, 16'h0, 16'(32'h20 | (s << 1)), 0, 16'h0), 0, "after_flush");
    end
    step(mk(0, 0, 0, 16'h0, 0, 16'h0, 16'h0004, 0, 16'h0), 0, "flush_drops_upd");

    // Reset coincident with an update drops it too
    step(mk(0, 0, 1, 16'h0006, 1, 16'h6666, 16'h0000, 0, 16'h0), 0, "pre_rst_alloc");
    step(mk(1, 0, 1, 16'h0008, 1, 16'h8888, 16'h0006, 1, 16'h6666), 0, "rst_cycle");
    step(mk(0, 0, 0, 16'h0, 0, 16'h0, 16'h0006, 0, 16'h0), 0, "after_rst");
    step(mk(0, 0, 0, 16'h0, 0, 16'h0, 16'h0008, 0, 16'h0), 0, "rst_drops_upd");

    // Random run against the reference model; small tag range forces conflicts and hits
    for (int n = 0; n < 10000; n++) begin
      v.rst     = ($urandom_range(255) == 0);
      v.flush   = ($urandom_range(127) == 0);
      v.upd_en  = ($urandom_range(1) == 1);
      v.taken   = ($urandom_range(2) != 0);
      v.upd_pc  = 16'(($urandom_range(3) << 5) | ($urandom_range(15) << 1) | $urandom_range(1));
      v.upd_tgt = 16'($urandom_range(65535));
      v.lk_pc   = 16'(($urandom_range(3) << 5) | ($urandom_range(15) << 1) | $urandom_range(1));
      v.exp_hit = 1'b0;
      v.exp_tgt = '0;
      step(v, 1, "random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
